// File: rtl/display_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl_if
//   Bundles the display-side signals of display_scan_ctrl.
//   Signal names keep the scan controller's own direction prefixes:
//     i_En          scan enable (0 = display dark, scanning frozen)
//     i_Nibble[3:0] digit value returned by the upstream 4:1 multiplexer
//     i_Dp_Mask     bit k lights the decimal point of digit k
//     i_Blank_Mask  bit k keeps digit k dark
//     o_Sel[1:0]    digit index / multiplexer select
//     o_Anodo[3:0]  digit enables, active-low, at most one low
//     o_Seg[6:0]    segments g..a, active-low
//     o_Dp          decimal point, active-low
//     o_Tick        one-cycle pulse when o_Sel advances
//   Modports: slave = scan controller, master = whoever drives the inputs.
// ---------------------------------------------------------------------------
interface display_scan_ctrl_if;
    logic       i_En;
    logic [3:0] i_Nibble;
    logic [3:0] i_Dp_Mask;
    logic [3:0] i_Blank_Mask;
    logic [1:0] o_Sel;
    logic [3:0] o_Anodo;
    logic [6:0] o_Seg;
    logic       o_Dp;
    logic       o_Tick;

    modport slave (
        input  i_En, i_Nibble, i_Dp_Mask, i_Blank_Mask,
        output o_Sel, o_Anodo, o_Seg, o_Dp, o_Tick
    );

    modport master (
        output i_En, i_Nibble, i_Dp_Mask, i_Blank_Mask,
        input  o_Sel, o_Anodo, o_Seg, o_Dp, o_Tick
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//   Scan controller for a 4-digit multiplexed 7-segment display. Each digit
//   slot of CLK_DIV cycles starts with BLANK_CYC cycles of all anodes off,
//   then shows the decoded nibble for the remaining cycles. The blank gap
//   lets the external multiplexer settle so no digit ghosts another's
//   segments.
//   Parameters: CLK_DIV   cycles per digit slot (must exceed BLANK_CYC)
//               BLANK_CYC dark cycles at the start of each slot (>= 2)
//   Ports:      i_Clk  rising-edge clock
//               i_Rst  asynchronous reset, active-high
//               bus    display_scan_ctrl_if.slave (see interface header)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    display_scan_ctrl_if.slave  bus
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - BLANK_CYC - 1);
    localparam logic [3:0]       ALL_OFF    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       sel_q;
    logic [3:0]       anodo_q;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic             tick_q;

    // Hex to active-low 7-segment, bit order g,f,e,d,c,b,a.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        // NOTE: a default on every path keeps combinational logic free of latches.
        seg = 7'h7F;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // NOTE: the reset is asynchronous so the anodes go dark the moment i_Rst
    // rises, without waiting for a clock edge.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            anodo_q <= ALL_OFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register
            // samples the pre-edge values, regardless of statement order.
            tick_q <= 1'b0;
            if (!bus.i_En) begin
                // Disable wins over everything, including the last SHOW cycle;
                // o_Sel and the segment registers are held.
                state_q <= IDLE;
                cnt_q   <= '0;
                anodo_q <= ALL_OFF;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= BLANK;
                        cnt_q   <= '0;
                        anodo_q <= ALL_OFF;
                    end
                    BLANK: begin
                        if (cnt_q == BLANK_LAST) begin
                            // Segments and anode load on the same edge so the
                            // digit never appears with stale segments.
                            state_q <= SHOW;
                            cnt_q   <= '0;
                            seg_q   <= hex7seg(bus.i_Nibble);
                            dp_q    <= ~bus.i_Dp_Mask[sel_q];
                            anodo_q <= bus.i_Blank_Mask[sel_q] ? ALL_OFF
                                                               : ~(4'b0001 << sel_q);
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    SHOW: begin
                        if (cnt_q == SHOW_LAST) begin
                            state_q <= BLANK;
                            cnt_q   <= '0;
                            anodo_q <= ALL_OFF;
                            sel_q   <= sel_q + 2'd1;
                            tick_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        anodo_q <= ALL_OFF;
                    end
                endcase
            end
        end
    end

    assign bus.o_Sel   = sel_q;
    assign bus.o_Anodo = anodo_q;
    assign bus.o_Seg   = seg_q;
    assign bus.o_Dp    = dp_q;
    assign bus.o_Tick  = tick_q;

endmodule
